pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register. It is the successor to the fixed-field inter-stage latches.
//  It carries one packed data bus and one packed control bus between stages, using a valid/ready handshake.
//  An optional 2-entry skid buffer lets upstream ready be fully registered.

---
 rtl/pipe_stage_reg.sv | 118 +++++++++++
 tb/tb_pipe_stage_reg.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised valid/ready pipeline stage register with optional skid buffer
// Main register M drives the outputs; skid register S (SKID=1) always holds the younger entry.
module pipe_stage_reg #(
  parameter int DATA_W          = 32,
  parameter int CTRL_W          = 16,
  parameter int SKID            = 1,
  parameter int BUBBLE_CLR_DATA = 1,
  parameter int CNT_W           = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              m_fire;
  logic              m_open;
  logic [1:0]        dropped;
  logic [CNT_W+1:0]  cnt_sum;

  // With the skid buffer, in_ready depends only on flops (and reset), never on out_ready.
  always_comb begin
    if (SKID != 0) in_ready_o = ~reset_i & ~s_valid_q;
    else           in_ready_o = ~reset_i & (~m_valid_q | out_ready_i);
  end

  assign accept  = in_valid_i & in_ready_o;
  assign m_fire  = m_valid_q & out_ready_i;
  assign m_open  = ~m_valid_q | out_ready_i;
  assign dropped = {1'b0, m_valid_q} + {1'b0, s_valid_q} - {1'b0, m_fire};
  assign cnt_sum = {2'b00, cnt_q} + {{CNT_W{1'b0}}, dropped};

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    cnt_d     = cnt_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      if (BUBBLE_CLR_DATA != 0) m_data_d = '0;
      cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
    end else if (m_open) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        m_ctrl_d  = s_ctrl_q;
        s_valid_d = accept;
        if (accept) begin
          s_data_d = in_data_i;
          s_ctrl_d = in_ctrl_i;
        end
      end else begin
        m_valid_d = accept;
        if (accept) begin
          m_data_d = in_data_i;
          m_ctrl_d = in_ctrl_i;
        end
      end
    end else if (accept && SKID != 0) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data_i;
      s_ctrl_d  = in_ctrl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ctrl_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_ctrl_q  <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  // A bubble always presents a NOP control word.
  assign out_valid_o = m_valid_q;
  assign out_ctrl_o  = m_valid_q ? m_ctrl_q : '0;
  assign out_data_o  = (BUBBLE_CLR_DATA != 0 && !m_valid_q) ? '0 : m_data_q;
  assign occupancy_o = {1'b0, m_valid_q} + {1'b0, s_valid_q};
  assign drop_cnt_o  = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - bench for pipe_stage_reg against a queue-based reference model
// u_skid: SKID=1, cleared bubbles, CNT_W=2; u_flat: SKID=0, held bubble data, CNT_W=16.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fl1, iv1, or1, fl0, iv0, or0;
  logic [31:0] id1, id0;
  logic [15:0] ic1, ic0;
  logic        rdy1, ov1, rdy0, ov0;
  logic [31:0] od1, od0;
  logic [15:0] oc1, oc0;
  logic [1:0]  occ1, occ0;
  logic [1:0]  dc1;
  logic [15:0] dc0;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(1), .BUBBLE_CLR_DATA(1), .CNT_W(2)) u_skid (
    .clk_i(clk), .reset_i(rst), .flush_i(fl1), .in_valid_i(iv1), .in_ready_o(rdy1),
    .in_data_i(id1), .in_ctrl_i(ic1), .out_valid_o(ov1), .out_ready_i(or1),
    .out_data_o(od1), .out_ctrl_o(oc1), .occupancy_o(occ1), .drop_cnt_o(dc1));

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .SKID(0), .BUBBLE_CLR_DATA(0), .CNT_W(16)) u_flat (
    .clk_i(clk), .reset_i(rst), .flush_i(fl0), .in_valid_i(iv0), .in_ready_o(rdy0),
    .in_data_i(id0), .in_ctrl_i(ic0), .out_valid_o(ov0), .out_ready_i(or0),
    .out_data_o(od0), .out_ctrl_o(oc0), .occupancy_o(occ0), .drop_cnt_o(dc0));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each stage is a FIFO of {ctrl,data}, capacity 2 (skid) or 1 (flat).
  logic [47:0] q1[$];
  logic [47:0] q0[$];
  int          cnt1 = 0;
  int          cnt0 = 0;
  logic [31:0] held0 = '0;

  // Inputs are already set; compare at mid-cycle, advance the model across the edge.
  task automatic tick();
    logic acc1, fire1, acc0, fire0;
    int   drop;
    #1;
    check("rdy1", rdy1, rst ? 1'b0 : (q1.size() < 2));
    check("vld1", ov1, q1.size() > 0);
    check("data1", od1, q1.size() > 0 ? q1[0][31:0] : 32'h0);
    check("ctrl1", oc1, q1.size() > 0 ? q1[0][47:32] : 16'h0);
    check("occ1", occ1, q1.size());
    check("cnt1", dc1, cnt1);
    check("rdy0", rdy0, rst ? 1'b0 : (q0.size() == 0 || or0));
    check("vld0", ov0, q0.size() > 0);
    check("data0", od0, q0.size() > 0 ? q0[0][31:0] : held0);
    check("ctrl0", oc0, q0.size() > 0 ? q0[0][47:32] : 16'h0);
    check("occ0", occ0, q0.size());
    check("cnt0", dc0, cnt0);
    acc1  = iv1 && !rst && q1.size() < 2;
    fire1 = q1.size() > 0 && or1;
    acc0  = iv0 && !rst && (q0.size() == 0 || or0);
    fire0 = q0.size() > 0 && or0;
    @(posedge clk);
    if (rst) begin
      q1.delete(); q0.delete();
      cnt1 = 0; cnt0 = 0; held0 = '0;
    end else begin
      if (fl1) begin
        drop = q1.size() - int'(fire1);
        cnt1 = (cnt1 + drop > 3) ? 3 : cnt1 + drop;
        q1.delete();
      end else begin
        if (fire1) void'(q1.pop_front());
        if (acc1) q1.push_back({ic1, id1});
      end
      if (fl0) begin
        drop = q0.size() - int'(fire0);
        cnt0 = (cnt0 + drop > 65535) ? 65535 : cnt0 + drop;
        q0.delete();
      end else begin
        if (fire0) void'(q0.pop_front());
        if (acc0) begin
          q0.push_back({ic0, id0});
          held0 = id0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic put1(input logic v, input logic [31:0] d, input logic [15:0] c, input logic r, input logic f);
    iv1 = v; id1 = d; ic1 = c; or1 = r; fl1 = f;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    fl1 = 0; iv1 = 0; or1 = 0; id1 = '0; ic1 = '0;
    fl0 = 0; iv0 = 0; or0 = 0; id0 = '0; ic0 = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;

    // Stream of 8 through both stages
    for (int i = 0; i < 8; i++) begin
      iv0 = 1; id0 = 32'h10 + i; ic0 = 16'(i); or0 = 1;
      put1(1, 32'h10 + i, 16'(i), 1, 0);
    end
    iv0 = 0;
    put1(0, 0, 0, 1, 0);
    put1(0, 0, 0, 1, 0);

    // Stall for 3 cycles mid-stream: skid fills, in_ready drops
    put1(1, 32'h20, 16'h1, 1, 0);
    put1(1, 32'h21, 16'h2, 0, 0);
    put1(1, 32'h22, 16'h3, 0, 0);
    check("stall_occ", occ1, 2);
    check("stall_rdy", rdy1, 0);
    put1(1, 32'h23, 16'h4, 0, 0);
    for (int i = 0; i < 4; i++) put1(1, 32'h24 + i, 16'(5 + i), 1, 0);
    put1(0, 0, 0, 1, 0);
    put1(0, 0, 0, 1, 0);

    // Flush with two held entries and an offered entry; then saturation 2,3,3
    for (int k = 0; k < 3; k++) begin
      put1(1, 32'h30 + k, 16'h11, 0, 0);
      put1(1, 32'h40 + k, 16'h12, 0, 0);
      check("pre_flush_occ", occ1, 2);
      put1(1, 32'hdead, 16'hbeef, 0, 1);
      check("flush_vld", ov1, 0);
      check("flush_data", od1, 0);
      check("flush_ctrl", oc1, 0);
      check("flush_cnt", dc1, k == 0 ? 2 : 3);
      put1(0, 0, 0, 1, 0);
    end

    // Reset while stalled at occupancy 2, then one-cycle latency afterwards
    put1(1, 32'h50, 16'h5, 0, 0);
    put1(1, 32'h51, 16'h6, 0, 0);
    rst = 1'b1;
    put1(0, 0, 0, 0, 0);
    check("rst_rdy", rdy1, 0);
    check("rst_vld", ov1, 0);
    check("rst_cnt", dc1, 0);
    rst = 1'b0;
    put1(1, 32'h60, 16'h7, 1, 0);
    check("post_rst_vld", ov1, 1);
    check("post_rst_data", od1, 32'h60);

    // Random traffic on both stages with occasional flushes
    for (int n = 0; n < 1000; n++) begin
      iv0 = ($urandom_range(0, 9) < 7); or0 = ($urandom_range(0, 9) < 6);
      id0 = $urandom; ic0 = 16'($urandom); fl0 = ($urandom_range(0, 29) == 0);
      put1($urandom_range(0, 9) < 7, $urandom, 16'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 29) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
